// File: rtl/alu_pkg.sv
// Shared types for the ALU commit stage: opcode encoding, commit FSM states and defaults.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 7;
    localparam int DEPTH_DEF  = 4;
    localparam int OP_W       = 5;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_LV   = 5'd1,
        OP_MLT  = 5'd2,
        OP_DIV  = 5'd3,
        OP_REST = 5'd4,
        OP_SUM  = 5'd5,
        OP_CP   = 5'd6,
        OP_B    = 5'd7,
        OP_BEG  = 5'd8,
        OP_SLR  = 5'd9,
        OP_GP   = 5'd10
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } commit_state_e;

    // NOP and out-of-range opcodes never occupy a FIFO slot.
    function automatic logic op_is_legal(input logic [4:0] op);
        return (op != 5'd0) && (op <= 5'd10);
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// In-order commit buffer with registered head, synchronous flush and full/empty flags.
module commit_fifo
    import alu_pkg::*;
#(
    parameter int W     = 52,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Storage, pointers and occupancy; flush takes priority over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == {(AW+1){1'b0}});

endmodule

// File: rtl/alu_commit_stage.sv
// Commit end of the ALU: buffers result bundles and retires them in order as
// register writes, data-memory stores (req/ack) or PC redirects.
module alu_commit_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_branch,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_wren,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       commit_cnt
);

    localparam int ENT_W = OP_W + 2 * ADDR_W + DATA_W + 1;

    logic [ENT_W-1:0]  w_din;
    logic [ENT_W-1:0]  w_head;
    logic [4:0]        w_head_op;
    logic [ADDR_W-1:0] w_head_rd;
    logic [ADDR_W-1:0] w_head_br;
    logic [DATA_W-1:0] w_head_res;
    logic              w_head_wren;
    logic              w_full;
    logic              w_empty;
    logic              w_can_commit;
    logic              w_taken;
    logic              w_pop;
    logic              w_push;
    logic              w_in_ready;

    commit_state_e     r_state;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_redirect;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [15:0]       r_commit_cnt;

    assign w_din = {in_opcode, in_rd, in_branch, in_result, in_wren};
    assign {w_head_op, w_head_rd, w_head_br, w_head_res, w_head_wren} = w_head;

    // Handshake and pop decisions; a taken branch flushes and refuses the same-cycle bundle.
    always_comb begin
        w_can_commit = ((r_state == ST_IDLE) || (r_state == ST_COMMIT)) && !w_empty;
        w_taken      = w_can_commit &&
                       ((w_head_op == OP_B) ||
                        ((w_head_op == OP_BEG) && (w_head_br != {ADDR_W{1'b0}})));
        w_pop        = (w_can_commit && (w_head_op != OP_GP)) ||
                       ((r_state == ST_MEM_WAIT) && mem_ack);
        w_in_ready   = rst_n && (r_state != ST_FLUSH) && !w_taken && (!w_full || w_pop);
        w_push       = in_valid && w_in_ready && op_is_legal(in_opcode);
    end

    commit_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_taken),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Commit FSM: retires the head entry and drives all registered side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= {ADDR_W{1'b0}};
            r_rf_wdata    <= {DATA_W{1'b0}};
            r_mem_req     <= 1'b0;
            r_mem_addr    <= {ADDR_W{1'b0}};
            r_mem_wdata   <= {DATA_W{1'b0}};
            r_redirect    <= 1'b0;
            r_redirect_pc <= {ADDR_W{1'b0}};
            r_commit_cnt  <= 16'd0;
        end else begin
            r_rf_we    <= 1'b0;
            r_redirect <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COMMIT: begin
                    if (w_empty) begin
                        r_state <= ST_IDLE;
                    end else begin
                        case (w_head_op)
                            OP_GP: begin
                                r_mem_req   <= 1'b1;
                                r_mem_addr  <= w_head_rd;
                                r_mem_wdata <= w_head_res;
                                r_state     <= ST_MEM_WAIT;
                            end
                            OP_B, OP_BEG: begin
                                r_commit_cnt <= r_commit_cnt + 16'd1;
                                if (w_taken) begin
                                    r_redirect    <= 1'b1;
                                    r_redirect_pc <= w_head_br;
                                    r_state       <= ST_FLUSH;
                                end else begin
                                    r_state <= ST_COMMIT;
                                end
                            end
                            default: begin
                                // Entries without a write enable still retire and count.
                                r_commit_cnt <= r_commit_cnt + 16'd1;
                                if (w_head_wren) begin
                                    r_rf_we    <= 1'b1;
                                    r_rf_waddr <= w_head_rd;
                                    r_rf_wdata <= w_head_res;
                                end
                                r_state <= ST_COMMIT;
                            end
                        endcase
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_commit_cnt <= r_commit_cnt + 16'd1;
                        r_state      <= ST_COMMIT;
                    end
                end
                ST_FLUSH: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign commit_cnt  = r_commit_cnt;

endmodule

// File: tb/tb_alu_commit_stage.sv
// Scoreboard bench for alu_commit_stage: expected commit events are queued at push time
// and matched against register writes, accepted stores and redirects as they appear.
module tb_alu_commit_stage;

    localparam logic [4:0] C_NOP = 5'd0;
    localparam logic [4:0] C_LV  = 5'd1;
    localparam logic [4:0] C_DIV = 5'd3;
    localparam logic [4:0] C_SUM = 5'd5;
    localparam logic [4:0] C_CP  = 5'd6;
    localparam logic [4:0] C_B   = 5'd7;
    localparam logic [4:0] C_BEG = 5'd8;
    localparam logic [4:0] C_SLR = 5'd9;
    localparam logic [4:0] C_GP  = 5'd10;
    localparam int K_RF  = 0;
    localparam int K_MEM = 1;
    localparam int K_RED = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [6:0]  in_rd;
    logic [6:0]  in_branch;
    logic [31:0] in_result;
    logic        in_wren;
    logic        rf_we;
    logic [6:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_req;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        redirect;
    logic [6:0]  redirect_pc;
    logic [15:0] commit_cnt;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   exp_cnt   = 0;
    int   ack_delay = 0;
    int   req_cyc   = 0;

    alu_commit_stage #(.DATA_W(32), .ADDR_W(7), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_branch   (in_branch),
        .in_result   (in_result),
        .in_wren     (in_wren),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .commit_cnt  (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic got(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check_val("ev_kind", 64'(kind), 64'(e.kind));
            check_val("ev_addr", 64'(a), 64'(e.addr));
            check_val("ev_data", 64'(d), 64'(e.data));
        end
    endtask

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we)              got(K_RF, 32'(rf_waddr), rf_wdata);
            if (redirect)           got(K_RED, 32'(redirect_pc), 32'd0);
            if (mem_req && mem_ack) got(K_MEM, 32'(mem_addr), mem_wdata);
        end
    end

    // Memory responder: acks after ack_delay request cycles.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mem_req) begin
                mem_ack = (req_cyc >= ack_delay);
                req_cyc++;
            end else begin
                mem_ack = 1'b0;
                req_cyc = 0;
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [6:0] rd, input logic [6:0] br,
                        input logic [31:0] res, input logic wren);
        int w;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_branch = br;
        in_result = res;
        in_wren   = wren;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) check_val("push_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check_val({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check_val({tag, "_cnt"}, 64'(commit_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 5'd0;
        in_rd     = 7'd0;
        in_branch = 7'd0;
        in_result = 32'd0;
        in_wren   = 1'b0;
        #12;
        check_val("rst_rf_we", 64'(rf_we), 64'd0);
        check_val("rst_mem_req", 64'(mem_req), 64'd0);
        check_val("rst_redirect", 64'(redirect), 64'd0);
        check_val("rst_cnt", 64'(commit_cnt), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 64'(in_ready), 64'd1);

        // Single sum: register write one cycle after the push edge.
        expect_ev(K_RF, 32'd3, 32'h15); exp_cnt++;
        send(C_SUM, 7'd3, 7'd0, 32'h15, 1'b1);
        idle();
        @(negedge clk);
        check_val("lat_early", 64'(rf_we), 64'd0);
        @(negedge clk);
        check_val("lat_rf", 64'(rf_we), 64'd1);
        drain("sum");

        // Mixed ops: NOP and illegal opcode discarded, write-less DIV counted silently.
        expect_ev(K_RF, 32'd7, 32'hDEADBEEF); exp_cnt++;
        send(C_LV, 7'd7, 7'd0, 32'hDEADBEEF, 1'b1);
        send(C_NOP, 7'd8, 7'd0, 32'h1111, 1'b1);
        send(5'd15, 7'd9, 7'd0, 32'h2222, 1'b1);
        exp_cnt++;
        send(C_DIV, 7'd10, 7'd0, 32'h3333, 1'b0);
        expect_ev(K_RF, 32'h7F, 32'hFFFFFFFF); exp_cnt++;
        send(C_SLR, 7'h7F, 7'd0, 32'hFFFFFFFF, 1'b1);
        expect_ev(K_RF, 32'd0, 32'd1); exp_cnt++;
        send(C_CP, 7'd0, 7'd0, 32'd1, 1'b1);
        idle();
        drain("mixed");

        // Store with three stalled ack cycles: request visible for four cycles.
        ack_delay = 3;
        expect_ev(K_MEM, 32'd9, 32'hAB); exp_cnt++;
        send(C_GP, 7'd9, 7'd0, 32'hAB, 1'b0);
        idle();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req) n++;
        end
        check_val("gp_req_len", 64'(n), 64'd4);
        drain("gp");

        // Taken BEG behind a stalled store: redirect, queued sums flushed.
        ack_delay = 4;
        expect_ev(K_MEM, 32'd5, 32'h5A); exp_cnt++;
        send(C_GP, 7'd5, 7'd0, 32'h5A, 1'b0);
        expect_ev(K_RED, 32'h22, 32'd0); exp_cnt++;
        send(C_BEG, 7'd1, 7'h22, 32'd0, 1'b0);
        send(C_SUM, 7'd1, 7'd0, 32'h101, 1'b1);
        send(C_SUM, 7'd2, 7'd0, 32'h102, 1'b1);
        idle();
        drain("flush");
        expect_ev(K_RF, 32'd4, 32'h44); exp_cnt++;
        send(C_SUM, 7'd4, 7'd0, 32'h44, 1'b1);
        idle();
        drain("post_flush");

        // Not-taken BEG retires quietly; unconditional B always redirects.
        ack_delay = 0;
        exp_cnt++;
        send(C_BEG, 7'd2, 7'd0, 32'd0, 1'b0);
        expect_ev(K_RF, 32'd6, 32'h66); exp_cnt++;
        send(C_SUM, 7'd6, 7'd0, 32'h66, 1'b1);
        expect_ev(K_RED, 32'h11, 32'd0); exp_cnt++;
        send(C_B, 7'd0, 7'h11, 32'd0, 1'b0);
        idle();
        drain("branch");

        // Stalled store fills the FIFO; fifth bundle waits, order preserved.
        ack_delay = 1000;
        expect_ev(K_MEM, 32'd9, 32'hAB); exp_cnt++;
        send(C_GP, 7'd9, 7'd0, 32'hAB, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_ev(K_RF, 32'(10 + i), 32'(32'h200 + i)); exp_cnt++;
            if (i < 3) send(C_SUM, 7'(10 + i), 7'd0, 32'(32'h200 + i), 1'b1);
        end
        @(posedge clk);
        #1;
        in_opcode = C_SUM;
        in_rd     = 7'd13;
        in_result = 32'h203;
        in_wren   = 1'b1;
        @(negedge clk);
        check_val("full_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        check_val("full_hold", 64'(in_ready), 64'd0);
        ack_delay = 0;
        send(C_SUM, 7'd13, 7'd0, 32'h203, 1'b1);
        idle();
        drain("full");

        // Reset while a store is pending: request drops at once, FIFO cleared.
        ack_delay = 1000;
        expect_ev(K_MEM, 32'd3, 32'h33);
        send(C_GP, 7'd3, 7'd0, 32'h33, 1'b0);
        expect_ev(K_MEM, 32'd4, 32'h44);
        send(C_GP, 7'd4, 7'd0, 32'h44, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        check_val("pre_rst_req", 64'(mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_mem_req", 64'(mem_req), 64'd0);
        check_val("arst_mem_addr", 64'(mem_addr), 64'd0);
        check_val("arst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_val("arst_cnt", 64'(commit_cnt), 64'd0);
        check_val("arst_ready", 64'(in_ready), 64'd0);
        sb.delete();
        exp_cnt   = 0;
        ack_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_ev(K_RF, 32'd2, 32'h22); exp_cnt++;
        send(C_SUM, 7'd2, 7'd0, 32'h22, 1'b1);
        idle();
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
